// File: rtl/tdc_measurement_sequencer_pkg.sv
// Shared types and constants for the TDC measurement sequencer.
// The optional build macro TDC_SEQ_AUTO_REARM_EN is consumed by the top module.
package tdc_seq_pkg;

  // Sequencer state encoding.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMING    = 3'd1,
    WAIT_HIT  = 3'd2,
    WAIT_FINE = 3'd3,
    PUSH      = 3'd4
  } seq_state_t;

  // Timeout records carry all ones; sliced to the timestamp width by users.
  localparam logic [63:0] TS_TIMEOUT_DATA = '1;

  // Timestamp width: coarse count concatenated above the fine code.
  function automatic int ts_width(input int coarse_bits, input int fine_bits);
    return coarse_bits + fine_bits;
  endfunction

endpackage

// File: rtl/tdc_measurement_sequencer_if.sv
// Timestamp stream interface: valid/ready handshake plus payload.
interface tdc_measurement_sequencer_if #(
  parameter int DATA_W = 22
) ();
  logic              ts_valid;
  logic              ts_ready;
  logic [DATA_W-1:0] ts_data;
  logic              ts_timeout;

  modport master (output ts_valid, output ts_data, output ts_timeout, input ts_ready);
  modport slave  (input ts_valid, input ts_data, input ts_timeout, output ts_ready);
endinterface

// File: rtl/tdc_measurement_sequencer_fifo.sv
// Small first-word-fall-through FIFO for {timeout, data} records with a
// sticky overflow flag. A push into a full FIFO is only dropped when no pop
// happens in the same cycle.
module tdc_seq_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 22
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_timeout,
  input  logic              pop_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_timeout,
  input  logic              clear_overflow,
  output logic              overflow
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [DATA_W:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             overflow_reg;
  logic             empty, full, rd_en, wr_en, drop;
  logic [DATA_W:0]  head;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == DEPTH_CNT);
  assign rd_en = !empty && pop_ready;
  assign wr_en = push && (!full || rd_en);
  assign drop  = push && full && !rd_en;
  assign head  = mem[rd_ptr_reg];

  // Head is forced to zero while empty so the idle bus reads as zero.
  assign out_valid   = !empty;
  assign out_data    = empty ? '0 : head[DATA_W-1:0];
  assign out_timeout = empty ? 1'b0 : head[DATA_W];
  assign overflow    = overflow_reg;

  // Storage array, written without reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_reg] <= {push_timeout, push_data};
  end

  // Pointers, occupancy and sticky overflow (set beats clear).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (drop) overflow_reg <= 1'b1;
      else if (clear_overflow) overflow_reg <= 1'b0;
    end
  end
endmodule

// File: rtl/tdc_measurement_sequencer.sv
// Sequences one fine TDC channel through measurement windows: arms the chain,
// counts coarse cycles until a hit or timeout, waits for the encoder, merges
// coarse and fine into a timestamp and queues it in a small FIFO.
// Optional: TDC_SEQ_AUTO_REARM_EN makes arm level-sensitive and re-arms
// straight from PUSH while arm is held.
module tdc_measurement_sequencer
  import tdc_seq_pkg::*;
#(
  parameter int FINE_BITS      = 6,
  parameter int COARSE_BITS    = 16,
  parameter int FINE_LATENCY   = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int ARM_CYCLES     = 2,
  parameter int DEPTH          = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 arm,
  input  logic                 hit_fired,
  input  logic [FINE_BITS-1:0] value_fine,
  output logic                 tdc_reset,
  output logic                 busy,
  tdc_measurement_sequencer_if.master ts_if,
  output logic                 overflow,
  input  logic                 clear_overflow
);
  localparam int TS_W   = ts_width(COARSE_BITS, FINE_BITS);
  localparam int ARM_W  = $clog2(ARM_CYCLES + 1);
  localparam int FINE_W = $clog2(FINE_LATENCY + 1);
  localparam logic [ARM_W-1:0]       ARM_LAST     = ARM_W'(ARM_CYCLES - 1);
  localparam logic [FINE_W-1:0]      FINE_LAST    = FINE_W'(FINE_LATENCY - 1);
  localparam logic [COARSE_BITS-1:0] TIMEOUT_LAST = COARSE_BITS'(TIMEOUT_CYCLES - 1);

  seq_state_t             state_reg;
  logic                   tdc_reset_reg, busy_reg, arm_prev_reg;
  logic [COARSE_BITS-1:0] coarse_reg, coarse_hit_reg;
  logic [ARM_W-1:0]       arm_cnt_reg;
  logic [FINE_W-1:0]      fine_cnt_reg;
  logic [TS_W-1:0]        pend_data_reg;
  logic                   pend_timeout_reg;
  logic                   start_req;
  logic [TS_W:0]          ts_wide;
  logic [TS_W-1:0]        ts_sat;

`ifdef TDC_SEQ_AUTO_REARM_EN
  assign start_req = arm;
`else
  assign start_req = arm && !arm_prev_reg;
`endif

  // coarse*2^FINE_BITS - fine with one guard bit; a borrow means the hit
  // landed before the first coarse tick, so clamp to zero.
  assign ts_wide = {1'b0, coarse_hit_reg, {FINE_BITS{1'b0}}}
                 - {{(COARSE_BITS + 1){1'b0}}, value_fine};
  assign ts_sat  = ts_wide[TS_W] ? '0 : ts_wide[TS_W-1:0];

  assign tdc_reset = tdc_reset_reg;
  assign busy      = busy_reg;

  // Measurement FSM with registered tdc_reset/busy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      tdc_reset_reg    <= 1'b1;
      busy_reg         <= 1'b0;
      arm_prev_reg     <= 1'b0;
      coarse_reg       <= '0;
      coarse_hit_reg   <= '0;
      arm_cnt_reg      <= '0;
      fine_cnt_reg     <= '0;
      pend_data_reg    <= '0;
      pend_timeout_reg <= 1'b0;
    end else begin
      arm_prev_reg <= arm;
      case (state_reg)
        IDLE: begin
          if (start_req) begin
            state_reg   <= ARMING;
            busy_reg    <= 1'b1;
            arm_cnt_reg <= '0;
            coarse_reg  <= '0;
          end
        end
        ARMING: begin
          if (arm_cnt_reg == ARM_LAST) begin
            state_reg     <= WAIT_HIT;
            tdc_reset_reg <= 1'b0;
          end else begin
            arm_cnt_reg <= arm_cnt_reg + 1'b1;
          end
        end
        WAIT_HIT: begin
          if (hit_fired) begin
            coarse_hit_reg <= coarse_reg;
            fine_cnt_reg   <= '0;
            state_reg      <= WAIT_FINE;
          end else if (coarse_reg == TIMEOUT_LAST) begin
            pend_data_reg    <= TS_TIMEOUT_DATA[TS_W-1:0];
            pend_timeout_reg <= 1'b1;
            tdc_reset_reg    <= 1'b1;
            state_reg        <= PUSH;
          end else begin
            coarse_reg <= coarse_reg + 1'b1;
          end
        end
        WAIT_FINE: begin
          if (fine_cnt_reg == FINE_LAST) begin
            pend_data_reg    <= ts_sat;
            pend_timeout_reg <= 1'b0;
            tdc_reset_reg    <= 1'b1;
            state_reg        <= PUSH;
          end else begin
            fine_cnt_reg <= fine_cnt_reg + 1'b1;
          end
        end
        PUSH: begin
`ifdef TDC_SEQ_AUTO_REARM_EN
          if (arm) begin
            state_reg   <= ARMING;
            arm_cnt_reg <= '0;
            coarse_reg  <= '0;
          end else begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
`else
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
`endif
        end
        default: begin
          state_reg     <= IDLE;
          busy_reg      <= 1'b0;
          tdc_reset_reg <= 1'b1;
        end
      endcase
    end
  end

  tdc_seq_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (TS_W)
  ) u_fifo (
    .clock          (clock),
    .reset          (reset),
    .push           (state_reg == PUSH),
    .push_data      (pend_data_reg),
    .push_timeout   (pend_timeout_reg),
    .pop_ready      (ts_if.ts_ready),
    .out_valid      (ts_if.ts_valid),
    .out_data       (ts_if.ts_data),
    .out_timeout    (ts_if.ts_timeout),
    .clear_overflow (clear_overflow),
    .overflow       (overflow)
  );
endmodule

// File: doc/tdc_measurement_sequencer.md
Name: tdc_measurement_sequencer

Overview:
- Sequences one fine TDC channel and its thermometer-to-binary encoder through measurement windows.
- Arms the capture chain by releasing its reset, and runs a coarse counter until the capture pulse arrives.
- Waits the encoder's fixed latency, then merges coarse and fine parts into a single timestamp.
- Buffers timestamps in a small FIFO behind a valid/ready interface.

Parameters:
- FINE_BITS, 6: width of the encoded fine value from the encoder.
- COARSE_BITS, 16: width of the coarse clock-cycle counter.
- FINE_LATENCY, 4: cycles from hit_fired to a stable value_fine.
- TIMEOUT_CYCLES, 4096: coarse count that ends an armed window with no hit. Must be ≤ 2^COARSE_BITS.
- ARM_CYCLES, 2: cycles tdc_reset stays asserted while arming.
- DEPTH, 4: output FIFO entries. Power of two, ≥ 2.

Ports:
- clock, input, 1: single system clock.
- reset, input, 1: asynchronous, active-high reset.
- arm, input, 1: request a measurement window.
- hit_fired, input, 1: clock-synchronous one-cycle pulse; the TDC has captured a hit.
- value_fine, input, FINE_BITS: encoded fine value.
- tdc_reset, output, 1: holds the TDC chain and encoder in reset.
- busy, output, 1: high in any state other than IDLE.
- ts_valid, output, 1: FIFO not empty.
- ts_ready, input, 1: consumer accepts the head entry.
- ts_data, output, COARSE_BITS+FINE_BITS: timestamp at the FIFO head.
- ts_timeout, output, 1: the head entry is a timeout record.
- overflow, output, 1: sticky; a record was dropped because the FIFO was full.
- clear_overflow, input, 1: clears overflow.

Behaviour:
- Reset values: state IDLE, tdc_reset=1, busy=0, ts_valid=0, ts_data=0, ts_timeout=0, overflow=0, FIFO empty, coarse=0.
- Reset may arrive mid-operation. It aborts immediately and returns everything to the reset values above.
- State IDLE:
  - tdc_reset=1.
  - A rising edge of arm (registered previous value) moves to ARMING.
  - arm pulses while busy are ignored.
- State ARMING:
  - tdc_reset=1 for ARM_CYCLES cycles, then move to WAIT_HIT.
  - coarse is cleared on entry.
- State WAIT_HIT:
  - tdc_reset=0; coarse increments every cycle, starting at 0 on the first WAIT_HIT cycle.
  - hit_fired=1: latch coarse_hit = coarse for that cycle and move to WAIT_FINE.
  - coarse == TIMEOUT_CYCLES-1 with no hit: move to PUSH with the timeout flag set and data all ones.
  - hit_fired together with the timeout cycle: the hit wins.
- State WAIT_FINE:
  - tdc_reset=0 for exactly FINE_LATENCY cycles.
  - On the last cycle, sample value_fine and move to PUSH.
  - hit_fired pulses here are ignored.
- State PUSH (one cycle):
  - Write one FIFO entry. tdc_reset=1. Move to IDLE.
- Timestamp arithmetic:
  - ts = coarse_hit·2^FINE_BITS − value_fine, computed in COARSE_BITS+FINE_BITS+1 bits.
  - A negative result (coarse_hit=0, fine>0) saturates to 0.
- End-to-end latency: the entry becomes ts_valid 2 cycles after the last WAIT_FINE cycle (PUSH, then FIFO write).
- FIFO:
  - Pop when ts_valid && ts_ready.
  - Push while full with no pop: drop the entry and set overflow.
  - Push and pop in the same cycle while full: both are accepted and nothing is dropped.
  - Push and pop in the same cycle while empty: the entry is written, then appears next cycle.
- overflow: set has priority over a clear_overflow in the same cycle.

Optional Feature:
- TDC_SEQ_AUTO_REARM_EN defined:
  - arm is level-sensitive.
  - From PUSH, go directly to ARMING (skipping IDLE) while arm=1; go to IDLE when arm=0.
- Not defined:
  - arm is edge-detected; exactly one window per rising edge.

Decomposition:
- Package tdc_seq_pkg: state encoding (IDLE, ARMING, WAIT_HIT, WAIT_FINE, PUSH), the timeout data constant (all ones), and a timestamp-width localparam helper.
- Sub-module tdc_seq_fifo: synchronous FIFO of DEPTH entries with {timeout, data} payload, full/empty flags, and the drop/overflow logic.

Test Plan:
- Basic hit: arm pulse; hit_fired at coarse=10; value_fine=5 → single entry ts_data=635, ts_timeout=0; tdc_reset low only during WAIT_HIT and WAIT_FINE.
- Timeout: TIMEOUT_CYCLES=16, no hit → entry ts_data all ones, ts_timeout=1; busy falls 2 cycles after coarse=15.
- Saturation: hit at coarse=0, value_fine=7 → ts_data=0.
- Backpressure: ts_ready=0 and 5 measurements with DEPTH=4 → 4 entries kept in order, overflow=1; clear_overflow → overflow=0.
- Concurrency and arm filtering: arm while busy → ignored, no extra entry; full FIFO with ts_ready=1 in the push cycle → no drop, overflow stays 0.
- Reset mid-WAIT_FINE: assert reset → tdc_reset=1 and ts_valid=0 immediately, no entry produced. With TDC_SEQ_AUTO_REARM_EN and arm held high → back-to-back windows, each ARMING lasting 2 cycles.
